// File: rtl/demux_8_collector.sv
// Eight-slot frame collector: distributes a valid/ready word stream into registered
// outputs W0..W7 and presents the complete frame with its own valid/ready handshake.
module demux_8_collector #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] in_data,
    input  logic         in_valid,
    input  logic         in_use_sel,
    input  logic [2:0]   in_sel,
    output logic         in_ready,
    input  logic         clear,
    output logic         frame_valid,
    input  logic         frame_ready,
    output logic [7:0]   fill_mask,
    output logic [N-1:0] W0,
    output logic [N-1:0] W1,
    output logic [N-1:0] W2,
    output logic [N-1:0] W3,
    output logic [N-1:0] W4,
    output logic [N-1:0] W5,
    output logic [N-1:0] W6,
    output logic [N-1:0] W7
);

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

    state_t       r_state;
    state_t       w_next_state;
    logic [2:0]   r_wr_ptr;
    logic [7:0]   r_fill_mask;
    logic [N-1:0] r_slots [8];

    logic         w_accept;
    logic [2:0]   w_target;
    logic [7:0]   w_onehot;
    logic         w_release;

    assign in_ready    = (r_state == FILL);
    assign frame_valid = (r_state == FULL);
    assign fill_mask   = r_fill_mask;

    assign w_accept  = in_valid & in_ready & ~clear;
    assign w_target  = in_use_sel ? in_sel : r_wr_ptr;
    assign w_onehot  = 8'b0000_0001 << w_target;
    assign w_release = (r_state == FULL) & frame_ready;

    // clear dominates both the fill completion and the frame release
    always_comb begin
        w_next_state = r_state;
        if (clear) begin
            w_next_state = FILL;
        end else begin
            case (r_state)
                FILL: if (w_accept && ((r_fill_mask | w_onehot) == 8'hFF)) w_next_state = FULL;
                FULL: if (frame_ready) w_next_state = FILL;
                default: w_next_state = FILL;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= FILL;
            r_wr_ptr    <= 3'd0;
            r_fill_mask <= 8'h00;
            for (int k = 0; k < 8; k++) begin
                r_slots[k] <= '0;
            end
        end else begin
            r_state <= w_next_state;
            if (clear || w_release) begin
                r_fill_mask <= 8'h00;
                r_wr_ptr    <= 3'd0;
            end else if (w_accept) begin
                r_slots[w_target] <= in_data;
                r_fill_mask       <= r_fill_mask | w_onehot;
                if (!in_use_sel) begin
                    r_wr_ptr <= r_wr_ptr + 3'd1;
                end
            end
        end
    end

    assign W0 = r_slots[0];
    assign W1 = r_slots[1];
    assign W2 = r_slots[2];
    assign W3 = r_slots[3];
    assign W4 = r_slots[4];
    assign W5 = r_slots[5];
    assign W6 = r_slots[6];
    assign W7 = r_slots[7];

endmodule

// File: tb/tb_demux_8_collector.sv
// Directed bench for demux_8_collector: one task per scenario, inline expected values.
module tb_demux_8_collector;

    localparam int N = 32;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] in_data;
    logic         in_valid;
    logic         in_use_sel;
    logic [2:0]   in_sel;
    logic         in_ready;
    logic         clear;
    logic         frame_valid;
    logic         frame_ready;
    logic [7:0]   fill_mask;
    logic [N-1:0] W0, W1, W2, W3, W4, W5, W6, W7;
    logic [N-1:0] w_out [8];

    int checks = 0;
    int errors = 0;

    demux_8_collector #(.N(N)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_use_sel(in_use_sel), .in_sel(in_sel), .in_ready(in_ready), .clear(clear),
        .frame_valid(frame_valid), .frame_ready(frame_ready), .fill_mask(fill_mask),
        .W0(W0), .W1(W1), .W2(W2), .W3(W3), .W4(W4), .W5(W5), .W6(W6), .W7(W7)
    );

    assign w_out[0] = W0;
    assign w_out[1] = W1;
    assign w_out[2] = W2;
    assign w_out[3] = W3;
    assign w_out[4] = W4;
    assign w_out[5] = W5;
    assign w_out[6] = W6;
    assign w_out[7] = W7;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after the rising edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic use_sel, input logic [2:0] sel, input logic [N-1:0] data);
        in_valid   = 1'b1;
        in_use_sel = use_sel;
        in_sel     = sel;
        in_data    = data;
        cyc();
        in_valid   = 1'b0;
    endtask

    task automatic release_frame();
        frame_ready = 1'b1;
        cyc();
        frame_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cyc();
        cyc();
        checks++; if (fill_mask !== 8'h00) begin errors++; $display("[TB] FAIL reset_mask got %h want 00", fill_mask); end
        checks++; if (frame_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b want 0", frame_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready got %b want 1", in_ready); end
        for (int k = 0; k < 8; k++) begin
            checks++; if (w_out[k] !== '0) begin errors++; $display("[TB] FAIL reset_W%0d got %h want 0", k, w_out[k]); end
        end
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_auto_fill();
        for (int k = 0; k < 8; k++) begin
            write_word(1'b0, 3'd0, N'(32'h10 + k));
            if (k == 6) begin
                checks++; if (frame_valid !== 1'b0) begin errors++; $display("[TB] FAIL auto_early_valid got %b want 0", frame_valid); end
                checks++; if (fill_mask !== 8'h7F) begin errors++; $display("[TB] FAIL auto_mask7 got %h want 7f", fill_mask); end
            end
        end
        checks++; if (frame_valid !== 1'b1) begin errors++; $display("[TB] FAIL auto_valid got %b want 1", frame_valid); end
        checks++; if (fill_mask !== 8'hFF) begin errors++; $display("[TB] FAIL auto_mask got %h want ff", fill_mask); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL auto_ready got %b want 0", in_ready); end
        for (int k = 0; k < 8; k++) begin
            checks++; if (w_out[k] !== N'(32'h10 + k)) begin errors++; $display("[TB] FAIL auto_W%0d got %h want %h", k, w_out[k], 32'h10 + k); end
        end
        release_frame();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL auto_release_ready got %b want 1", in_ready); end
        checks++; if (fill_mask !== 8'h00) begin errors++; $display("[TB] FAIL auto_release_mask got %h want 00", fill_mask); end
        checks++; if (W5 !== 32'h15) begin errors++; $display("[TB] FAIL auto_release_keepW5 got %h want 15", W5); end
    endtask

    task automatic test_explicit_reverse();
        for (int k = 7; k >= 0; k--) begin
            write_word(1'b1, 3'(k), N'(32'hA0 + k));
            if (k == 1) begin
                checks++; if (fill_mask !== 8'hFE) begin errors++; $display("[TB] FAIL rev_mask7 got %h want fe", fill_mask); end
                checks++; if (frame_valid !== 1'b0) begin errors++; $display("[TB] FAIL rev_early_valid got %b want 0", frame_valid); end
            end
        end
        checks++; if (frame_valid !== 1'b1) begin errors++; $display("[TB] FAIL rev_valid got %b want 1", frame_valid); end
        for (int k = 0; k < 8; k++) begin
            checks++; if (w_out[k] !== N'(32'hA0 + k)) begin errors++; $display("[TB] FAIL rev_W%0d got %h want %h", k, w_out[k], 32'hA0 + k); end
        end
        release_frame();
        write_word(1'b0, 3'd5, 32'h33);
        checks++; if (W0 !== 32'h33) begin errors++; $display("[TB] FAIL rev_ptr_W0 got %h want 33", W0); end
        checks++; if (W5 !== 32'hA5) begin errors++; $display("[TB] FAIL rev_sel_ignored_W5 got %h want a5", W5); end
        checks++; if (fill_mask !== 8'h01) begin errors++; $display("[TB] FAIL rev_ptr_mask got %h want 01", fill_mask); end
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        checks++; if (fill_mask !== 8'h00) begin errors++; $display("[TB] FAIL rev_clear_mask got %h want 00", fill_mask); end
    endtask

    task automatic test_overwrite_backpressure();
        logic [2:0] rest [7];
        rest = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd6, 3'd7};
        write_word(1'b1, 3'd3, 32'h5);
        checks++; if (W3 !== 32'h5) begin errors++; $display("[TB] FAIL ovw_first got %h want 5", W3); end
        write_word(1'b1, 3'd3, 32'h9);
        checks++; if (W3 !== 32'h9) begin errors++; $display("[TB] FAIL ovw_second got %h want 9", W3); end
        checks++; if (fill_mask !== 8'h08) begin errors++; $display("[TB] FAIL ovw_mask got %h want 08", fill_mask); end
        for (int k = 0; k < 7; k++) write_word(1'b1, rest[k], N'(32'h20 + rest[k]));
        checks++; if (frame_valid !== 1'b1) begin errors++; $display("[TB] FAIL ovw_valid got %b want 1", frame_valid); end
        in_valid = 1'b1; in_use_sel = 1'b1; in_sel = 3'd0; in_data = 32'hDEAD;
        for (int c = 0; c < 5; c++) begin
            cyc();
            checks++; if (W0 !== 32'h20) begin errors++; $display("[TB] FAIL bp_W0_c%0d got %h want 20", c, W0); end
            checks++; if ((fill_mask !== 8'hFF) || (frame_valid !== 1'b1)) begin errors++; $display("[TB] FAIL bp_hold_c%0d mask %h valid %b want ff 1", c, fill_mask, frame_valid); end
        end
        in_valid = 1'b0;
        release_frame();
        checks++; if (fill_mask !== 8'h00) begin errors++; $display("[TB] FAIL bp_release_mask got %h want 00", fill_mask); end
        checks++; if ((in_ready !== 1'b1) || (frame_valid !== 1'b0)) begin errors++; $display("[TB] FAIL bp_release_state ready %b valid %b want 1 0", in_ready, frame_valid); end
        checks++; if (W3 !== 32'h9) begin errors++; $display("[TB] FAIL bp_keepW3 got %h want 9", W3); end
    endtask

    task automatic test_pointer_wrap();
        for (int k = 0; k < 7; k++) write_word(1'b0, 3'd0, N'(32'h40 + k));
        release_frame();
        checks++; if (fill_mask !== 8'h7F) begin errors++; $display("[TB] FAIL wrap_ignored_ready got %h want 7f", fill_mask); end
        write_word(1'b0, 3'd0, 32'h47);
        checks++; if (W7 !== 32'h47) begin errors++; $display("[TB] FAIL wrap_W7 got %h want 47", W7); end
        checks++; if (frame_valid !== 1'b1) begin errors++; $display("[TB] FAIL wrap_valid got %b want 1", frame_valid); end
        release_frame();
        write_word(1'b0, 3'd0, 32'h50);
        checks++; if (W0 !== 32'h50) begin errors++; $display("[TB] FAIL wrap_W0 got %h want 50", W0); end
        checks++; if (fill_mask !== 8'h01) begin errors++; $display("[TB] FAIL wrap_mask got %h want 01", fill_mask); end
        clear = 1'b1;
        cyc();
        clear = 1'b0;
    endtask

    task automatic test_clear_priority();
        for (int k = 0; k < 4; k++) write_word(1'b0, 3'd0, N'(32'h60 + k));
        clear = 1'b1;
        write_word(1'b1, 3'd4, 32'hFF);
        clear = 1'b0;
        checks++; if (W4 !== 32'h44) begin errors++; $display("[TB] FAIL clr_W4 got %h want 44", W4); end
        checks++; if (fill_mask !== 8'h00) begin errors++; $display("[TB] FAIL clr_mask got %h want 00", fill_mask); end
        checks++; if (W3 !== 32'h63) begin errors++; $display("[TB] FAIL clr_keepW3 got %h want 63", W3); end
        for (int k = 0; k < 8; k++) write_word(1'b0, 3'd0, N'(32'h70 + k));
        checks++; if (W0 !== 32'h70) begin errors++; $display("[TB] FAIL clr_ptr_W0 got %h want 70", W0); end
        checks++; if (frame_valid !== 1'b1) begin errors++; $display("[TB] FAIL clr_full got %b want 1", frame_valid); end
        clear = 1'b1; frame_ready = 1'b1;
        cyc();
        clear = 1'b0; frame_ready = 1'b0;
        checks++; if ((frame_valid !== 1'b0) || (in_ready !== 1'b1)) begin errors++; $display("[TB] FAIL clr_full_state valid %b ready %b want 0 1", frame_valid, in_ready); end
        checks++; if (fill_mask !== 8'h00) begin errors++; $display("[TB] FAIL clr_full_mask got %h want 00", fill_mask); end
        checks++; if (W7 !== 32'h77) begin errors++; $display("[TB] FAIL clr_full_keepW7 got %h want 77", W7); end
    endtask

    task automatic test_midframe_reset();
        for (int k = 0; k < 5; k++) write_word(1'b0, 3'd0, N'(32'h80 + k));
        checks++; if (fill_mask !== 8'h1F) begin errors++; $display("[TB] FAIL mid_mask got %h want 1f", fill_mask); end
        rst_n = 1'b0; clear = 1'b1;
        cyc();
        rst_n = 1'b1; clear = 1'b0;
        checks++; if ((fill_mask !== 8'h00) || (frame_valid !== 1'b0) || (in_ready !== 1'b1)) begin
            errors++; $display("[TB] FAIL mid_state mask %h valid %b ready %b want 00 0 1", fill_mask, frame_valid, in_ready);
        end
        for (int k = 0; k < 8; k++) begin
            checks++; if (w_out[k] !== '0) begin errors++; $display("[TB] FAIL mid_W%0d got %h want 0", k, w_out[k]); end
        end
        write_word(1'b0, 3'd0, 32'h99);
        checks++; if ((W0 !== 32'h99) || (fill_mask !== 8'h01)) begin errors++; $display("[TB] FAIL mid_after W0 %h mask %h want 99 01", W0, fill_mask); end
    endtask

    initial begin
        rst_n = 1'b0; in_data = '0; in_valid = 1'b0; in_use_sel = 1'b0;
        in_sel = 3'd0; clear = 1'b0; frame_ready = 1'b0;
        test_reset();
        test_auto_fill();
        test_explicit_reverse();
        test_overwrite_backpressure();
        test_pointer_wrap();
        test_clear_priority();
        test_midframe_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/demux_8_collector.md
Name: demux_8_collector

Overview:
- Inverse of the design's 8-to-1 N-bit selector: takes one N-bit stream and distributes words into eight registered N-bit outputs W0..W7.
- Gathers a frame of 8 layer/neuron results produced one per transaction, then presents them in parallel to the next stage.
- Valid/ready on both sides.
- Slot chosen by explicit 3-bit select or by an internal auto-increment pointer.

Parameters:
N, 32, data width of the input word and of each output slot

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset
in_data  input  N  word to store
in_valid  input  1  in_data/in_sel are valid this cycle
in_use_sel  input  1  1: write slot in_sel; 0: write slot at internal pointer
in_sel  input  3  explicit slot index (3'b000 selects W0 ... 3'b111 selects W7)
in_ready  output  1  collector can accept a word this cycle
clear  input  1  synchronous abort of the current frame
frame_valid  output  1  all eight slots written; W0..W7 form a complete frame
frame_ready  input  1  downstream consumes the frame
fill_mask  output  8  bit k set when slot k written in the current frame
W0..W7  output  N each  registered slot contents

Behaviour:
- States: FILL and FULL.
  - in_ready = (state == FILL), combinational from state.
  - frame_valid = (state == FULL).
- Reset (rst_n low at a rising edge):
  - state=FILL, wr_ptr=0, fill_mask=8'h00, W0..W7 = 0.
  - Resulting outputs: frame_valid=0, in_ready=1.
  - Reset overrides clear and all handshakes.
- Accept = in_valid & in_ready & !clear.
- On accept:
  - Target slot t = in_use_sel ? in_sel : wr_ptr.
  - W_t <= in_data; fill_mask[t] <= 1.
  - wr_ptr advances only when in_use_sel=0: wr_ptr <= wr_ptr+1, modulo 8 (7 wraps to 0).
  - When in_use_sel=1, wr_ptr is unchanged.
- Write latency: the new value appears on W_t and fill_mask the cycle after acceptance. Other slots are unchanged.
- Overwrite: a write to an already-set slot replaces its data, and fill_mask is unchanged. No error is raised.
- FILL -> FULL: when (fill_mask | onehot(t)) == 8'hFF on an accept. frame_valid rises the next cycle, in the same cycle W_t holds the last word.
- FULL:
  - in_ready=0; in_valid is ignored.
  - W0..W7 and fill_mask are held stable.
- FULL -> FILL on frame_ready=1:
  - fill_mask <= 0, wr_ptr <= 0.
  - W registers keep their values.
  - in_ready=1 the following cycle, giving a minimum one-cycle bubble between frames.
- clear=1 (state FILL or FULL):
  - Next state FILL, fill_mask <= 0, wr_ptr <= 0; W registers are kept.
  - clear has priority over accept and over frame_ready in the same cycle. A word presented with clear is not stored.
- frame_ready while in FILL is ignored.
- in_sel is ignored when in_use_sel=0.
- No combinational path from in_data to W outputs; all outputs except in_ready/frame_valid come directly from flops.

Test Plan:
- Reset then auto fill:
  - Stimulus: rst_n=0 for 2 cycles, then 8 accepts with in_use_sel=0 and data 0x10..0x17 back-to-back.
  - Response: W0=0x10 ... W7=0x17; fill_mask=0xFF and frame_valid=1 exactly one cycle after the 8th accept; in_ready=0.
- Explicit select, reverse order:
  - Stimulus: writes to in_sel=7..0 with data 0xA7..0xA0.
  - Response: Wk=0xA0+k; wr_ptr stays 0; frame_valid after the 8th write.
- Overwrite and backpressure:
  - Stimulus: write slot 3 = 0x5 then slot 3 = 0x9, then fill the remaining 7 slots. Hold frame_ready=0 for 5 cycles while driving in_valid=1.
  - Response: W3=0x9; nothing else changes in FULL.
  - Then frame_ready=1 for 1 cycle -> fill_mask=0 and in_ready=1 the next cycle.
- Pointer wrap:
  - Stimulus: 7 auto writes, then frame_ready before the 8th.
  - Response: frame_ready is ignored.
  - 8th auto write goes to W7, then a new frame's first auto write goes to W0.
- Clear priority:
  - Stimulus: 4 writes, then clear=1 together with in_valid=1 and data 0xFF to slot 4.
  - Response: W4 is unchanged; fill_mask=0; next auto write lands in W0.
  - Also: clear in FULL together with frame_ready -> FILL, mask 0.
- Mid-frame reset:
  - Stimulus: rst_n=0 after 5 writes.
  - Response: all W=0, fill_mask=0, frame_valid=0, in_ready=1 after the reset edge.
